bin_to_bcd: RTL
===============

BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 Parameter: WIDTH, 16, bit width of the binary input.
REQ-002 Parameter: DIGITS, 5, number of BCD output digits; 10^DIGITS SHALL exceed 2^WIDTH-1.
REQ-003 Parameter: DISP_DIGITS, 4, digits shown on the display; used only for the overflow check.
REQ-004 clk  input  1  single clock; all flops on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 bin_in  input  WIDTH  unsigned binary value, captured on the accepted start edge.
REQ-008 bcd_out  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-009 busy  output  1  high in CONV and DONE.
REQ-010 done  output  1  one-cycle result-valid pulse.
REQ-011 ovf  output  1  display-overflow flag; present only with BIN_BCD_OVF_EN.

Function
REQ-012 Conversion SHALL use iterative double-dabble: one add-3/shift iteration per clock.
- Each iteration adds 3 to every BCD digit >= 5.
- The {bcd, bin} register then shifts left by 1.
REQ-013 FSM states: IDLE, CONV, DONE.
- IDLE -> CONV on start=1: load bin_in, clear the BCD shift register, set iteration count to 0.
- CONV: stay for exactly WIDTH cycles, then -> DONE.
- DONE: stay 1 cycle, then -> IDLE.
REQ-014 Latency: with start sampled at edge E0, iterations occur at edges E1..E(WIDTH). done=1 in the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after start.
REQ-015 bcd_out SHALL update only when entering DONE and SHALL hold its value until the next DONE.
REQ-016 done SHALL be 1 only in DONE, never for more than one consecutive cycle.
REQ-017 start while busy=1 SHALL be ignored, with no queuing. A start sampled in the DONE cycle is also ignored.
REQ-018 bin_in changes after the capture edge SHALL NOT affect the running conversion.
REQ-019 The iteration counter SHALL be $clog2(WIDTH+1) bits wide. No arithmetic SHALL overflow its digit width: a digit is at most 12 after add-3.
REQ-020 Every input value 0 .. 2^WIDTH-1 SHALL be valid; there is no error condition in the base block.
REQ-021 Back-to-back operation: a start held high continuously SHALL produce one conversion every WIDTH+2 cycles.

Reset
REQ-022 rst=1 at a clock edge SHALL force:
- state=IDLE, counter=0, shift register=0
- bcd_out=0, busy=0, done=0, ovf=0
REQ-023 Reset SHALL take precedence over start in the same cycle.
REQ-024 Reset during CONV or DONE SHALL abort the conversion with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro BIN_BCD_OVF_EN defined:
- Port ovf exists.
- ovf is registered on entering DONE, set to 1 when the result >= 10^DISP_DIGITS (any digit at index >= DISP_DIGITS is nonzero), else 0.
- ovf holds its value until the next DONE or rst.
REQ-026 Macro BIN_BCD_OVF_EN undefined: port ovf and all its logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package bcd_pkg SHALL hold:
- the FSM state enum typedef
- the 4-bit BCD digit typedef
- the add-3 threshold constant (5)
REQ-028 Sub-module bcd_digit_adj (combinational: digit in, digit+3 out if >= 5) SHALL be instantiated DIGITS times inside bin_to_bcd.

Verification
REQ-029 rst, then start with bin_in=0 -> done pulses in cycle 17 after the start edge; bcd_out=20'h00000; busy high for 17 cycles.
REQ-030 bin_in=9801, then 65535, back-to-back with start held high -> bcd_out=20'h09801, then 20'h65535; done pulses 18 cycles apart.
REQ-031 Start pulses at cycles 3 and 10 of a conversion, with bin_in changed to 1234 -> ignored; the original result is unchanged; exactly one done.
REQ-032 rst asserted at CONV cycle 8 of bin_in=4095 -> next cycle all outputs 0, state IDLE, no done; a following start with 4095 -> 20'h04095.
REQ-033 With BIN_BCD_OVF_EN: bin_in=9999 -> ovf=0, bcd_out=20'h09999; bin_in=10000 -> ovf=1, bcd_out=20'h10000.
REQ-034 Exhaustive sweep 0..65535 against a reference model -> all bcd_out values match; done width is always 1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t ADD3_THRESH = 4'd5;
   localparam bcd_digit_t ADD3_VALUE  = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  bcd_digit_t digit,
   output bcd_digit_t digit_adj
);

   // Largest input is 9, so the corrected digit never exceeds 12.
   always_comb begin
      if (digit >= ADD3_THRESH) begin
         digit_adj = digit + ADD3_VALUE;
      end else begin
         digit_adj = digit;
      end
   end

endmodule

// File: rtl/bin_to_bcd.sv
// Iterative double-dabble binary-to-BCD converter, one add-3/shift per clock.
// Define BIN_BCD_OVF_EN to add the ovf display-overflow output.
module bin_to_bcd
   import bcd_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 5,
   parameter int DISP_DIGITS = 4
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    bin_in,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                busy,
   output logic                done
`ifdef BIN_BCD_OVF_EN
   ,
   output logic                ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int SR_W  = 4 * DIGITS + WIDTH;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   if (DISP_DIGITS > DIGITS) begin : g_bad_disp_digits
      $error("bin_to_bcd: DISP_DIGITS must not exceed DIGITS");
   end

   state_t              state_r;
   state_t              state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [WIDTH-1:0]    bin_r;
   logic [4*DIGITS-1:0] bcd_r;
   logic [4*DIGITS-1:0] adj_s;
   logic [4*DIGITS-1:0] bcd_out_r;
   logic [SR_W-1:0]     shift_s;
   logic                last_iter_s;
   logic                busy_r;
   logic                done_r;
   logic                busy_nxt_s;
   logic                done_nxt_s;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit     (bcd_r[4*g +: 4]),
         .digit_adj (adj_s[4*g +: 4])
      );
   end

   // The shift drops only the corrected top digit's MSB, which is always zero.
   assign shift_s     = {adj_s, bin_r} << 1'b1;
   assign last_iter_s = (cnt_r == LAST_ITER);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = ST_CONV;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_CONV: begin
            if (last_iter_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_CONV;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from the next state so busy/done come straight from flops.
   always_comb begin
      busy_nxt_s = 1'b0;
      done_nxt_s = 1'b0;
      case (state_nxt_s)
         ST_IDLE: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
         ST_CONV: begin
            busy_nxt_s = 1'b1;
            done_nxt_s = 1'b0;
         end
         ST_DONE: begin
            busy_nxt_s = 1'b1;
            done_nxt_s = 1'b1;
         end
         default: begin
            busy_nxt_s = 1'b0;
            done_nxt_s = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= '0;
         bin_r     <= '0;
         bcd_r     <= '0;
         bcd_out_r <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         busy_r <= busy_nxt_s;
         done_r <= done_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  bin_r <= bin_in;
                  bcd_r <= '0;
                  cnt_r <= '0;
               end
            end
            ST_CONV: begin
               bcd_r <= shift_s[SR_W-1:WIDTH];
               bin_r <= shift_s[WIDTH-1:0];
               cnt_r <= cnt_r + 1'b1;
               if (last_iter_s) begin
                  bcd_out_r <= shift_s[SR_W-1:WIDTH];
               end
            end
            ST_DONE: cnt_r <= '0;
            default: cnt_r <= '0;
         endcase
      end
   end

   assign bcd_out = bcd_out_r;
   assign busy    = busy_r;
   assign done    = done_r;

`ifdef BIN_BCD_OVF_EN
   logic ovf_r;
   logic ovf_nxt_s;

   // Any nonzero digit beyond the displayed ones means the display overflows.
   always_comb begin
      ovf_nxt_s = 1'b0;
      for (int i = DISP_DIGITS; i < DIGITS; i++) begin
         ovf_nxt_s = ovf_nxt_s | (|shift_s[WIDTH + 4*i +: 4]);
      end
   end

   // Overflow flag, captured together with bcd_out.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if ((state_r == ST_CONV) && last_iter_s) begin
         ovf_r <= ovf_nxt_s;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule
